// File: rtl/meal_scheduler.sv
// Time-of-day meal scheduler: 1 Hz seconds-of-day counter, programmable meal-time table,
// one-slot-per-cycle scan raising a held meal request, midnight pulse and missed-meal count.
module meal_scheduler #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_W      = 2,
    parameter int unsigned TIME_W      = 17,
    parameter int unsigned DAY_SECONDS = 86400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1s,
    input  logic              sched_enable,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [TIME_W-1:0] cfg_time,
    input  logic              cfg_en,
    input  logic              set_time_we,
    input  logic [TIME_W-1:0] set_time,
    input  logic              meal_ack,
    output logic              timesup,
    output logic [SLOT_W-1:0] meal_slot,
    output logic              newday,
    output logic [3:0]        missed_count,
    output logic [TIME_W-1:0] time_of_day,
    output logic              cfg_err
);

    localparam logic [TIME_W-1:0] DAY_MAX  = TIME_W'(DAY_SECONDS - 1);
    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            r_state;
    logic [SLOT_W-1:0] r_idx;
    logic              r_tick_pending;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] r_slot_time [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_slot_en;
    logic              r_timesup;
    logic [SLOT_W-1:0] r_meal_slot;
    logic              r_newday;
    logic [3:0]        r_missed;
    logic              r_cfg_err;

    logic w_cfg_bad;
    logic w_set_bad;
    logic w_match;

    assign w_cfg_bad = cfg_time > DAY_MAX;
    assign w_set_bad = set_time > DAY_MAX;
    assign w_match   = (r_state == StScan) && r_slot_en[r_idx] &&
                       (r_slot_time[r_idx] == r_time) && sched_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_idx          <= '0;
            r_tick_pending <= 1'b0;
            r_time         <= '0;
            r_slot_en      <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                r_slot_time[i] <= '0;
            end
            r_timesup      <= 1'b0;
            r_meal_slot    <= '0;
            r_newday       <= 1'b0;
            r_missed       <= '0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_newday  <= 1'b0;
            r_cfg_err <= (cfg_we && w_cfg_bad) || (set_time_we && w_set_bad);

            if (cfg_we && !w_cfg_bad) begin
                r_slot_time[cfg_slot] <= cfg_time;
                r_slot_en[cfg_slot]   <= cfg_en;
            end

            if (set_time_we && !w_set_bad) begin
                r_time <= set_time;
            end

            // A time load swallows any tick seen in the same cycle, including a pending one.
            unique case (r_state)
                StIdle: begin
                    if (set_time_we) begin
                        r_tick_pending <= 1'b0;
                    end else if (tick_1s || r_tick_pending) begin
                        r_tick_pending <= 1'b0;
                        r_state        <= StScan;
                        r_idx          <= '0;
                        if (r_time == DAY_MAX) begin
                            r_time   <= '0;
                            r_newday <= 1'b1;
                            r_missed <= '0;
                        end else begin
                            r_time <= r_time + TIME_W'(1);
                        end
                    end
                end
                StScan: begin
                    if (tick_1s && !set_time_we) begin
                        r_tick_pending <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= StIdle;
                    end
                    r_idx <= r_idx + SLOT_W'(1);
                end
                default: r_state <= StIdle;
            endcase

            // An ack coinciding with a new match hands the request straight to the new slot.
            if (!sched_enable) begin
                r_timesup <= 1'b0;
            end else if (w_match && (!r_timesup || meal_ack)) begin
                r_timesup   <= 1'b1;
                r_meal_slot <= r_idx;
            end else if (w_match) begin
                if (r_missed != 4'hF) begin
                    r_missed <= r_missed + 4'd1;
                end
            end else if (meal_ack) begin
                r_timesup <= 1'b0;
            end
        end
    end

    assign timesup      = r_timesup;
    assign meal_slot    = r_meal_slot;
    assign newday       = r_newday;
    assign missed_count = r_missed;
    assign time_of_day  = r_time;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_meal_scheduler.sv
// Bench for meal_scheduler: config/time-load vector table, hand-written scenario sequences,
// then randomized traffic compared every cycle against a cycle-counting reference model.
module tb_meal_scheduler;

    localparam int NS  = 4;
    localparam int DAY = 86400;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1s;
    logic        sched_enable;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic [16:0] cfg_time;
    logic        cfg_en;
    logic        set_time_we;
    logic [16:0] set_time;
    logic        meal_ack;
    logic        timesup;
    logic [1:0]  meal_slot;
    logic        newday;
    logic [3:0]  missed_count;
    logic [16:0] time_of_day;
    logic        cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    meal_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1s      (tick_1s),
        .sched_enable (sched_enable),
        .cfg_we       (cfg_we),
        .cfg_slot     (cfg_slot),
        .cfg_time     (cfg_time),
        .cfg_en       (cfg_en),
        .set_time_we  (set_time_we),
        .set_time     (set_time),
        .meal_ack     (meal_ack),
        .timesup      (timesup),
        .meal_slot    (meal_slot),
        .newday       (newday),
        .missed_count (missed_count),
        .time_of_day  (time_of_day),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_wait(input int extra);
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
        repeat (extra) step();
    endtask

    task automatic wr_slot(input int s, input int t, input logic en);
        cfg_we   = 1'b1;
        cfg_slot = 2'(s);
        cfg_time = 17'(t);
        cfg_en   = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic load_time(input int t);
        set_time_we = 1'b1;
        set_time    = 17'(t);
        step();
        set_time_we = 1'b0;
    endtask

    // Reference model: scan windows tracked by the cycle number their tick was accepted on.
    int c;
    int m_time, m_req, m_mslot, m_missed, m_newday, m_err, m_pending, m_start;
    int m_st [NS];
    int m_en [NS];

    task automatic model_reset();
        m_time = 0; m_req = 0; m_mslot = 0; m_missed = 0; m_newday = 0; m_err = 0;
        m_pending = 0; m_start = -100; c = 0;
        for (int i = 0; i < NS; i++) begin
            m_st[i] = 0;
            m_en[i] = 0;
        end
    endtask

    task automatic model_step();
        int  n_time, n_req, n_mslot, n_missed, n_newday, n_err, n_pending, n_start, idx;
        bit  scanning, match;
        scanning = (c >= m_start + 1) && (c <= m_start + NS);
        idx      = c - m_start - 1;
        match    = 0;
        if (scanning) match = m_en[idx] != 0 && m_st[idx] == m_time && sched_enable;
        n_time = m_time; n_req = m_req; n_mslot = m_mslot; n_missed = m_missed;
        n_newday = 0; n_pending = m_pending; n_start = m_start;
        n_err = (cfg_we && int'(cfg_time) >= DAY) || (set_time_we && int'(set_time) >= DAY);
        if (set_time_we) begin
            if (int'(set_time) < DAY) n_time = int'(set_time);
            if (!scanning) n_pending = 0;
        end else if (!scanning && (tick_1s || m_pending != 0)) begin
            n_start   = c;
            n_pending = 0;
            if (m_time == DAY - 1) begin
                n_time = 0; n_newday = 1; n_missed = 0;
            end else begin
                n_time = m_time + 1;
            end
        end else if (scanning && tick_1s) begin
            n_pending = 1;
        end
        if (!sched_enable) n_req = 0;
        else if (match && (m_req == 0 || meal_ack)) begin
            n_req = 1; n_mslot = idx;
        end else if (match) begin
            if (n_missed < 15) n_missed++;
        end else if (meal_ack) n_req = 0;
        if (cfg_we && int'(cfg_time) < DAY) begin
            m_st[cfg_slot] = int'(cfg_time);
            m_en[cfg_slot] = int'(cfg_en);
        end
        m_time = n_time; m_req = n_req; m_mslot = n_mslot; m_missed = n_missed;
        m_newday = n_newday; m_err = n_err; m_pending = n_pending; m_start = n_start;
    endtask

    typedef struct {
        logic        st_we;
        int          st_val;
        logic        cf_we;
        int          cf_slot;
        int          cf_time;
        logic        exp_err;
        int          exp_time;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 100,    1'b0, 0, 0,      1'b0, 100};
        vecs[1] = '{1'b1, 86400,  1'b0, 0, 0,      1'b1, 100};
        vecs[2] = '{1'b1, 86399,  1'b0, 0, 0,      1'b0, 86399};
        vecs[3] = '{1'b0, 0,      1'b1, 0, 86400,  1'b1, 86399};
        vecs[4] = '{1'b0, 0,      1'b1, 1, 5,      1'b0, 86399};
        vecs[5] = '{1'b1, 0,      1'b1, 2, 131071, 1'b1, 0};
        vecs[6] = '{1'b1, 90000,  1'b0, 0, 0,      1'b1, 0};
        vecs[7] = '{1'b0, 0,      1'b0, 0, 0,      1'b0, 0};

        reset = 1'b1; tick_1s = 0; sched_enable = 1; cfg_we = 0; cfg_slot = 0; cfg_time = 0;
        cfg_en = 0; set_time_we = 0; set_time = 0; meal_ack = 0;
        #3;
        check("rst_time", 32'(time_of_day), 0);
        check("rst_timesup", 32'(timesup), 0);
        check("rst_missed", 32'(missed_count), 0);
        step();
        @(negedge clk) reset = 1'b0;

        // Config / time-load table; slots written disabled so later scenarios are unaffected.
        for (int i = 0; i < 8; i++) begin
            set_time_we = vecs[i].st_we; set_time = 17'(vecs[i].st_val);
            cfg_we = vecs[i].cf_we; cfg_slot = 2'(vecs[i].cf_slot);
            cfg_time = 17'(vecs[i].cf_time); cfg_en = 1'b0;
            step();
            set_time_we = 0; cfg_we = 0;
            check($sformatf("vec%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_time", i), 32'(time_of_day), 32'(vecs[i].exp_time));
            check($sformatf("vec%0d_newday", i), 32'(newday), 0);
        end

        // Single slot, request held without ack, cleared by ack.
        wr_slot(0, 10, 1);
        load_time(0);
        repeat (9) tick_wait(4);
        check("s1_time9", 32'(time_of_day), 9);
        check("s1_no_req", 32'(timesup), 0);
        tick_1s = 1; step(); tick_1s = 0;
        check("s1_time10", 32'(time_of_day), 10);
        check("s1_req_t1", 32'(timesup), 0);
        step();
        check("s1_req_t2", 32'(timesup), 1);
        check("s1_slot", 32'(meal_slot), 0);
        repeat (20) step();
        check("s1_held", 32'(timesup), 1);
        meal_ack = 1; step(); meal_ack = 0;
        check("s1_acked", 32'(timesup), 0);

        // Two slots at the same second: lowest wins, other counted missed.
        wr_slot(0, 0, 0);
        wr_slot(1, 5, 1);
        wr_slot(3, 5, 1);
        load_time(4);
        tick_wait(4);
        check("s2_time", 32'(time_of_day), 5);
        check("s2_req", 32'(timesup), 1);
        check("s2_slot", 32'(meal_slot), 1);
        check("s2_missed1", 32'(missed_count), 1);
        wr_slot(3, 6, 1);
        tick_wait(4);
        check("s2_missed2", 32'(missed_count), 2);
        check("s2_slot_kept", 32'(meal_slot), 1);

        // Midnight wrap clears the missed count.
        wr_slot(2, 7, 1);
        tick_wait(4);
        check("s3_missed3", 32'(missed_count), 3);
        load_time(86399);
        check("s3_loaded", 32'(time_of_day), 86399);
        check("s3_no_newday_on_load", 32'(newday), 0);
        tick_1s = 1; step(); tick_1s = 0;
        check("s3_wrap_time", 32'(time_of_day), 0);
        check("s3_newday", 32'(newday), 1);
        check("s3_missed_clr", 32'(missed_count), 0);
        step();
        check("s3_newday_pulse", 32'(newday), 0);
        repeat (3) step();

        // Ack in the same cycle a new slot matches hands the request over.
        meal_ack = 1; step(); meal_ack = 0;
        check("s4_cleared", 32'(timesup), 0);
        wr_slot(1, 0, 0);
        wr_slot(3, 0, 0);
        wr_slot(0, 20, 1);
        wr_slot(2, 21, 1);
        load_time(19);
        tick_wait(4);
        check("s4_req0", 32'(timesup), 1);
        check("s4_slot0", 32'(meal_slot), 0);
        tick_1s = 1; step(); tick_1s = 0;
        step(); step();
        meal_ack = 1; step(); meal_ack = 0;
        check("s4_req_kept", 32'(timesup), 1);
        check("s4_slot2", 32'(meal_slot), 2);
        check("s4_missed", 32'(missed_count), 0);
        repeat (2) step();

        // Rejected slot write.
        wr_slot(1, 86400, 1);
        check("s5_cfg_err", 32'(cfg_err), 1);
        step();
        check("s5_cfg_err_pulse", 32'(cfg_err), 0);
        meal_ack = 1; step(); meal_ack = 0;
        load_time(86399);
        tick_wait(4);
        check("s5_time0", 32'(time_of_day), 0);
        check("s5_no_match", 32'(timesup), 0);

        // Asynchronous reset during an active request and scan.
        wr_slot(0, 1, 1);
        tick_wait(4);
        check("s6_req", 32'(timesup), 1);
        tick_1s = 1; step(); tick_1s = 0;
        #2 reset = 1'b1;
        #1;
        check("s6_rst_timesup", 32'(timesup), 0);
        check("s6_rst_slot", 32'(meal_slot), 0);
        check("s6_rst_time", 32'(time_of_day), 0);
        check("s6_rst_missed", 32'(missed_count), 0);
        check("s6_rst_newday", 32'(newday), 0);
        check("s6_rst_err", 32'(cfg_err), 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) tick_wait(4);
        check("s6_time3", 32'(time_of_day), 3);
        check("s6_no_req", 32'(timesup), 0);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        #3;
        @(negedge clk) reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000 && n_fail < 50; i++) begin
            tick_1s      = ($urandom_range(0, 2) == 0);
            meal_ack     = ($urandom_range(0, 7) == 0);
            sched_enable = ($urandom_range(0, 39) != 0);
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_slot     = 2'($urandom_range(0, 3));
            cfg_en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) cfg_time = 17'(DAY + $urandom_range(0, 100));
            else cfg_time = 17'((m_time + $urandom_range(0, 12)) % DAY);
            set_time_we  = (i == 0) || ($urandom_range(0, 299) == 0);
            if (i == 0) set_time = 17'(86385);
            else if ($urandom_range(0, 3) == 0) set_time = 17'(DAY + $urandom_range(0, 50));
            else set_time = 17'(86390 + $urandom_range(0, 9));
            model_step();
            step();
            c++;
            check("rnd_timesup", 32'(timesup), 32'(m_req));
            check("rnd_meal_slot", 32'(meal_slot), 32'(m_mslot));
            check("rnd_newday", 32'(newday), 32'(m_newday));
            check("rnd_missed", 32'(missed_count), 32'(m_missed));
            check("rnd_time", 32'(time_of_day), 32'(m_time));
            check("rnd_cfg_err", 32'(cfg_err), 32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
